// File: rtl/adc_rx_pkg.sv
// Shared frame constants, FSM encoding and helpers for the dual-ADC serial capture engine.
// Optional averaging is enabled by defining ADC_RX_AVG_EN.
package adc_rx_pkg;
  localparam int ADC_RX_WAIT_SCKS = 2;
  localparam int ADC_RX_WORD_SCKS = 16;
  localparam int ADC_RX_BITS      = 14;
  localparam int ADC_RX_AVG_N     = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CONV    = 3'd1,
    S_WAIT    = 3'd2,
    S_SHIFT_I = 3'd3,
    S_SHIFT_Q = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic [15:0] sext14(input logic [ADC_RX_BITS-1:0] v);
    return {{(16-ADC_RX_BITS){v[ADC_RX_BITS-1]}}, v};
  endfunction
endpackage

// File: rtl/adc_rx_lane.sv
// One SDO line: input register, 14-bit shifter, sign extension, optional 4-frame average.
// Averaging is compiled in only when ADC_RX_AVG_EN is defined.
module adc_rx_lane
  import adc_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        sdo,
  input  logic        smp,
  input  logic        i_done,
  input  logic        q_done,
`ifdef ADC_RX_AVG_EN
  input  logic        first,
  input  logic        last,
`endif
  output logic [15:0] wi,
  output logic [15:0] wq
);
  logic                   sdo_q;
  logic [ADC_RX_BITS-1:0] sh, i_word;

  // I is parked once its word ends, since the shifter is reused for Q
  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_q  <= 1'b0;
      sh     <= '0;
      i_word <= '0;
    end else begin
      sdo_q <= sdo;
      if (smp)    sh     <= {sh[ADC_RX_BITS-2:0], sdo_q};
      if (i_done) i_word <= sh;
    end
  end

`ifdef ADC_RX_AVG_EN
  logic signed [17:0] acc_i, acc_q, sum_i, sum_q;

  always_comb begin
    sum_i = (first ? 18'sd0 : acc_i) + $signed({{4{i_word[ADC_RX_BITS-1]}}, i_word});
    sum_q = (first ? 18'sd0 : acc_q) + $signed({{4{sh[ADC_RX_BITS-1]}}, sh});
  end

  // sum[17:2] is the floor-divided-by-4 result truncated to 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_i <= '0;
      acc_q <= '0;
      wi    <= '0;
      wq    <= '0;
    end else if (q_done) begin
      acc_i <= sum_i;
      acc_q <= sum_q;
      if (last) begin
        wi <= sum_i[17:2];
        wq <= sum_q[17:2];
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      wi <= '0;
      wq <= '0;
    end else if (q_done) begin
      wi <= sext14(i_word);
      wq <= sext14(sh);
    end
  end
`endif
endmodule

// File: rtl/adc_rx.sv
// Dual-ADC capture engine: CONVP/SCK generation, frame FSM, and F/R lane deserialisers.
// Define ADC_RX_AVG_EN to run 4 frames per start and output their average.
module adc_rx
  import adc_rx_pkg::*;
#(
  parameter int SCK_DIV = 2
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        overrun,
  output logic        conv,
  output logic        sck,
  input  logic        sdo_f,
  input  logic        sdo_r,
  output logic        valid,
  output logic [15:0] fi,
  output logic [15:0] fq,
  output logic [15:0] ri,
  output logic [15:0] rq
);
  localparam logic [4:0] PH_LAST   = 5'(2*SCK_DIV-1);
  localparam logic [4:0] PH_HIGH   = 5'(SCK_DIV);
  localparam logic [4:0] WAIT_LAST = 5'(ADC_RX_WAIT_SCKS-1);
  localparam logic [4:0] WORD_LAST = 5'(ADC_RX_WORD_SCKS-1);
  localparam logic [4:0] BITS_N    = 5'(ADC_RX_BITS);

  state_t     state, state_d;
  logic [4:0] ph, per;
  logic       per_end, word_end, last_frame, shifting, smp, i_done, q_done;

  assign per_end  = ph == PH_LAST;
  assign word_end = per_end && per == WORD_LAST;
  assign shifting = state == S_SHIFT_I || state == S_SHIFT_Q;
  assign smp      = shifting && per_end && per < BITS_N;
  assign i_done   = state == S_SHIFT_I && word_end;
  assign q_done   = state == S_SHIFT_Q && word_end;

`ifdef ADC_RX_AVG_EN
  logic [1:0] frm;
  assign last_frame = frm == 2'(ADC_RX_AVG_N-1);

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) frm <= '0;
    else if (q_done)            frm <= frm + 2'd1;
  end
`else
  assign last_frame = 1'b1;
`endif

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:    if (start)                     state_d = S_CONV;
      S_CONV:    if (per_end)                   state_d = S_WAIT;
      S_WAIT:    if (per_end && per == WAIT_LAST) state_d = S_SHIFT_I;
      S_SHIFT_I: if (word_end)                  state_d = S_SHIFT_Q;
      S_SHIFT_Q: if (word_end)                  state_d = last_frame ? S_DONE : S_CONV;
      S_DONE:                                   state_d = S_IDLE;
      default:                                  state_d = S_IDLE;
    endcase
  end

  // ph = clk within the SCK period, per = SCK period within the current state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ph    <= '0;
      per   <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE || state_d != state || per_end) ph <= '0;
      else                                                 ph <= ph + 5'd1;
      if (state == S_IDLE || state_d != state) per <= '0;
      else if (per_end)                        per <= per + 5'd1;
    end
  end

  assign conv    = state == S_CONV;
  assign sck     = (state == S_WAIT || shifting) && ph >= PH_HIGH;
  assign busy    = state != S_IDLE;
  assign valid   = state == S_DONE;
  assign overrun = start && busy;

  adc_rx_lane u_lane_f (
    .clk(clk), .rst(rst), .sdo(sdo_f), .smp(smp), .i_done(i_done), .q_done(q_done),
`ifdef ADC_RX_AVG_EN
    .first(frm == 2'd0), .last(last_frame),
`endif
    .wi(fi), .wq(fq)
  );

  adc_rx_lane u_lane_r (
    .clk(clk), .rst(rst), .sdo(sdo_r), .smp(smp), .i_done(i_done), .q_done(q_done),
`ifdef ADC_RX_AVG_EN
    .first(frm == 2'd0), .last(last_frame),
`endif
    .wi(ri), .wq(rq)
  );
endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: ADC serial model, frame-timing reference model and directed frames.
module tb_adc_rx;
  localparam int SCK_DIV = 2;
  localparam int P       = 2*SCK_DIV;
  localparam int FLEN    = 35*P;
`ifdef ADC_RX_AVG_EN
  localparam int          NFR   = 4;
  localparam int          A_LAT = 561;
  localparam logic [15:0] A_FI  = 16'hF334;
`else
  localparam int          NFR   = 1;
  localparam int          A_LAT = 141;
  localparam logic [15:0] A_FI  = 16'hF333;
`endif
  localparam int LEN = NFR*FLEN + 1;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sdo_f = 1'b1, sdo_r = 1'b1;
  logic busy, overrun, conv, sck, valid;
  logic [15:0] fi, fq, ri, rq;
  logic [15:0] e_fi, e_fq, e_ri, e_rq;
  logic [13:0] wfi[4], wfq[4], wri[4], wrq[4];
  int checks = 0, failures = 0;
  int mt = 0, cyc = 0, t0 = 0, vld_at = -1, n_vld = 0, n_ovr = 0, n_sck = 0, edge_n = 0;
  int s0, o0, v0;

  adc_rx #(.SCK_DIV(SCK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .overrun(overrun),
    .conv(conv), .sck(sck), .sdo_f(sdo_f), .sdo_r(sdo_r), .valid(valid),
    .fi(fi), .fq(fq), .ri(ri), .rq(rq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic int sx(input logic [13:0] v);
    int x;
    x = int'(v);
    if (v[13]) x = x - 16384;
    return x;
  endfunction

  // reference: mt = cycles since the accepted start (0 = idle)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)          mt <= 0;
    else if (mt == 0) mt <= start ? 1 : 0;
    else              mt <= (mt == LEN) ? 0 : mt + 1;
  end

  always @(negedge clk) begin
    logic [4:0] e;
    int ph;
    if (cyc > 0) begin
      ph   = (mt - 1) % FLEN;
      e[4] = mt != 0;
      e[3] = mt != 0 && mt < LEN && ph < P;
      e[2] = mt != 0 && mt < LEN && ph >= P && ((mt - 1) % P) >= SCK_DIV;
      e[1] = mt == LEN;
      e[0] = start && mt != 0;
      chk("ctl{busy,conv,sck,valid,overrun}", 64'({busy, conv, sck, valid, overrun}), 64'(e));
      if (e[1]) chk("data{fi,fq,ri,rq}", {fi, fq, ri, rq}, {e_fi, e_fq, e_ri, e_rq});
      if (valid) begin n_vld++; vld_at = cyc - t0; end
      if (overrun) n_ovr++;
    end
  end

  // ADC: shifts MSB first, changing SDO on SCK rise; junk on unsampled edges
  always @(posedge conv or posedge sck) begin
    int k, cur;
    if (conv) edge_n = 0;
    else begin
      edge_n++;
      n_sck++;
      k   = edge_n;
      cur = (mt > 0) ? ((mt - 1) / FLEN) % 4 : 0;
      if (k >= 3 && k <= 16) begin
        sdo_f = wfi[cur][16-k];
        sdo_r = wri[cur][16-k];
      end else if (k >= 19 && k <= 32) begin
        sdo_f = wfq[cur][32-k];
        sdo_r = wrq[cur][32-k];
      end else begin
        sdo_f = k[0];
        sdo_r = ~k[0];
      end
    end
  end

  task automatic load(input logic [13:0] a, input logic [13:0] b, input logic [13:0] c,
                      input logic [13:0] d, input int inc);
    int sf = 0, sq = 0, sr = 0, ss = 0;
    for (int k = 0; k < 4; k++) begin
      wfi[k] = a + 14'(k*inc);
      wfq[k] = b;
      wri[k] = c;
      wrq[k] = d;
    end
    for (int k = 0; k < NFR; k++) begin
      sf += sx(wfi[k]); sq += sx(wfq[k]); sr += sx(wri[k]); ss += sx(wrq[k]);
    end
    e_fi = 16'((NFR == 4) ? (sf >>> 2) : sf);
    e_fq = 16'((NFR == 4) ? (sq >>> 2) : sq);
    e_ri = 16'((NFR == 4) ? (sr >>> 2) : sr);
    e_rq = 16'((NFR == 4) ? (ss >>> 2) : ss);
  endtask

  task automatic go;
    t0    = cyc;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_valid;
    int n0 = n_vld;
    int i  = 0;
    while (n_vld == n0 && i < LEN + 50) begin tick; i++; end
    chk("valid_seen", 64'(n_vld != n0), 64'(1));
    repeat (3) tick;
  endtask

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_data", {fi, fq, ri, rq}, 64'h0);
    chk("rst_ctl", 64'({busy, conv, sck, valid, overrun}), 64'h0);
    repeat (20) tick;
    chk("idle_sck_edges", 64'(n_sck), 64'(0));

    load(14'h3333, 14'h2223, 14'h38E3, 14'h3C3D, 1);
    s0 = n_sck;
    go;
    wait_valid;
    chk("a_latency", 64'(vld_at), 64'(A_LAT));
    chk("a_fi", 64'(fi), 64'(A_FI));
    chk("a_fq", 64'(fq), 64'(16'hE223));
    chk("a_ri", 64'(ri), 64'(16'hF8E3));
    chk("a_rq", 64'(rq), 64'(16'hFC3D));
    chk("a_sck_edges", 64'(n_sck - s0), 64'(34*NFR));

    load(14'h1234, 14'h0ABC, 14'h2000, 14'h1FFF, 0);
    o0 = n_ovr; v0 = n_vld;
    go;
    repeat (49) tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    wait_valid;
    repeat (10) tick;
    chk("b_overruns", 64'(n_ovr - o0), 64'(1));
    chk("b_valids", 64'(n_vld - v0), 64'(1));
    chk("b_fi", 64'(fi), 64'(16'h1234));
    chk("b_ri", 64'(ri), 64'(16'hE000));

    load(14'h0001, 14'h3FFF, 14'h1FFF, 14'h2001, 0);
    go;
    repeat (LEN - 1) tick;
    o0 = n_ovr;
    start = 1'b1;
    tick;
    tick;
    start = 1'b0;
    chk("c_valid_cycle_overrun", 64'(n_ovr - o0), 64'(1));
    wait_valid;
    chk("c_fq", 64'(fq), 64'(16'hFFFF));
    chk("c_rq", 64'(rq), 64'(16'hE001));

    go;
    repeat (59) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_mid_ctl", 64'({busy, conv, sck}), 64'h0);
    chk("rst_mid_fi", 64'(fi), 64'h0);
    v0 = n_vld;
    repeat (LEN + 10) tick;
    chk("rst_mid_no_valid", 64'(n_vld - v0), 64'(0));

    load(14'h1234, 14'h0100, 14'h3FFE, 14'h0002, 0);
    go;
    wait_valid;
    chk("d_fi", 64'(fi), 64'(16'h1234));
    chk("d_ri", 64'(ri), 64'(16'hFFFE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
